// File: rtl/alu_iter_pkg.sv
// ---------------------------------------------------------------------------
// alu_iter_pkg
// Shared types for the execute-stage ALU: the 32-bit data word, the ALU_CTRL_*
// operation codes emitted by the decode stage's ALU control generator, the
// shift-kind encoding used by the iterative shifter, and small helpers that
// classify a control word.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_iter_pkg;

    typedef logic [31:0] word_t;

    // Operation codes. Code 0 is deliberately left unassigned so that an
    // all-zero control word falls through to the PASS behaviour.
    localparam word_t ALU_CTRL_ADD  = 32'd1;
    localparam word_t ALU_CTRL_SUB  = 32'd2;
    localparam word_t ALU_CTRL_XOR  = 32'd3;
    localparam word_t ALU_CTRL_OR   = 32'd4;
    localparam word_t ALU_CTRL_AND  = 32'd5;
    localparam word_t ALU_CTRL_CLR  = 32'd6;
    localparam word_t ALU_CTRL_PASS = 32'd7;
    localparam word_t ALU_CTRL_SLL  = 32'd8;
    localparam word_t ALU_CTRL_SRL  = 32'd9;
    localparam word_t ALU_CTRL_SRA  = 32'd10;
    localparam word_t ALU_CTRL_SLT  = 32'd11;
    localparam word_t ALU_CTRL_SLTU = 32'd12;
    localparam word_t ALU_CTRL_SGE  = 32'd13;
    localparam word_t ALU_CTRL_SGEU = 32'd14;
    localparam word_t ALU_CTRL_SEQ  = 32'd15;
    localparam word_t ALU_CTRL_SNE  = 32'd16;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_kind_t;

    // True for the three ops that go through the iterative shifter.
    function automatic logic alu_is_shift(input word_t ctrl);
        return (ctrl == ALU_CTRL_SLL) || (ctrl == ALU_CTRL_SRL) ||
               (ctrl == ALU_CTRL_SRA);
    endfunction

    // Maps a shift control code to the compact kind held during iteration.
    function automatic shift_kind_t alu_shift_kind(input word_t ctrl);
        shift_kind_t kind;
        kind = SH_SLL;
        if (ctrl == ALU_CTRL_SRL) kind = SH_SRL;
        if (ctrl == ALU_CTRL_SRA) kind = SH_SRA;
        return kind;
    endfunction

endpackage

// File: rtl/alu_logic.sv
// ---------------------------------------------------------------------------
// alu_logic
// Purely combinational result generator for every single-cycle ALU op:
// add/sub, bitwise logic, CSR-style clear and pass, and the compares.
// Shift codes and unknown codes produce operand B (PASS); the shifts
// themselves are handled by the iterative shifter in alu_iter.
// Ports:
//   i_ctrl   in  32  ALU_CTRL_* code
//   i_a      in  32  operand A
//   i_b      in  32  operand B
//   o_result out 32  combinational result
// ---------------------------------------------------------------------------
module alu_logic
    import alu_iter_pkg::*;
(
    input  word_t i_ctrl,
    input  word_t i_a,
    input  word_t i_b,
    output word_t o_result
);

    logic w_lt_s;
    logic w_lt_u;
    logic w_eq;

    // Compare primitives shared by the six compare ops.
    always_comb begin
        w_lt_s = $signed(i_a) < $signed(i_b);
        w_lt_u = i_a < i_b;
        w_eq   = i_a == i_b;
    end

    // Op decode. Anything not listed, including 0, behaves as PASS.
    always_comb begin
        o_result = i_b;
        case (i_ctrl)
            ALU_CTRL_ADD:  o_result = i_a + i_b;
            ALU_CTRL_SUB:  o_result = i_a - i_b;
            ALU_CTRL_XOR:  o_result = i_a ^ i_b;
            ALU_CTRL_OR:   o_result = i_a | i_b;
            ALU_CTRL_AND:  o_result = i_a & i_b;
            ALU_CTRL_CLR:  o_result = i_a & ~i_b;
            ALU_CTRL_PASS: o_result = i_b;
            ALU_CTRL_SLT:  o_result = {31'd0, w_lt_s};
            ALU_CTRL_SLTU: o_result = {31'd0, w_lt_u};
            ALU_CTRL_SGE:  o_result = {31'd0, ~w_lt_s};
            ALU_CTRL_SGEU: o_result = {31'd0, ~w_lt_u};
            ALU_CTRL_SEQ:  o_result = {31'd0, w_eq};
            ALU_CTRL_SNE:  o_result = {31'd0, ~w_eq};
            default:       o_result = i_b;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// ---------------------------------------------------------------------------
// alu_iter
// Execute-stage ALU with a registered result and valid/ready handshakes.
// Non-shift ops complete in one cycle; shifts iterate SHIFT_STEP bits per
// cycle. One op is in flight at a time, but a held result can be replaced
// by a new op in the same cycle it is consumed.
// Parameters:
//   SHIFT_STEP  bits shifted per iteration (1, 2, 4, 8, 16 or 32)
// Ports:
//   clk        in   1  core clock
//   rst        in   1  asynchronous active-high reset
//   flush      in   1  synchronous kill of in-flight op and held result
//   in_valid   in   1  operands and ctrl present
//   in_ready   out  1  block accepts this cycle
//   in_ctrl    in  32  ALU_CTRL_* code
//   in_a       in  32  operand A
//   in_b       in  32  operand B (shift amount in [4:0] for shifts)
//   out_valid  out  1  result held
//   out_ready  in   1  consumer takes result
//   out_result out 32  registered result
// ---------------------------------------------------------------------------
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int SHIFT_STEP = 1
)
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  in_valid,
    output logic  in_ready,
    input  word_t in_ctrl,
    input  word_t in_a,
    input  word_t in_b,
    output logic  out_valid,
    input  logic  out_ready,
    output word_t out_result
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } alu_iter_state_t;

    localparam logic [5:0] STEP_W = 6'(SHIFT_STEP);

    alu_iter_state_t r_state;
    alu_iter_state_t w_state_next;
    word_t           r_sh;
    word_t           w_sh_next;
    logic [4:0]      r_cnt;
    logic [4:0]      w_cnt_next;
    shift_kind_t     r_kind;
    shift_kind_t     w_kind_next;
    word_t           r_result;
    word_t           w_result_next;

    word_t           w_logic_result;
    word_t           w_shifted;
    logic [5:0]      w_step;
    logic [4:0]      w_cnt_dec;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_in_is_shift;
    logic [4:0]      w_in_shamt;

    alu_logic u_alu_logic (
        .i_ctrl   (in_ctrl),
        .i_a      (in_a),
        .i_b      (in_b),
        .o_result (w_logic_result)
    );

    // Handshake and input classification. A shift of zero is a plain
    // pass-through of A and so completes in a single cycle like any other op.
    always_comb begin
        w_in_ready    = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        w_accept      = in_valid && w_in_ready;
        w_in_is_shift = alu_is_shift(in_ctrl);
        w_in_shamt    = in_b[4:0];
    end

    // One shifter iteration: shift by min(SHIFT_STEP, remaining count) so the
    // final step never overshoots the requested amount.
    always_comb begin
        w_step    = ({1'b0, r_cnt} < STEP_W) ? {1'b0, r_cnt} : STEP_W;
        w_cnt_dec = r_cnt - w_step[4:0];
        case (r_kind)
            SH_SLL:  w_shifted = r_sh << w_step;
            SH_SRL:  w_shifted = r_sh >> w_step;
            SH_SRA:  w_shifted = $signed(r_sh) >>> w_step;
            default: w_shifted = r_sh;
        endcase
    end

    // Next-state and datapath-load logic. Flush wins over everything and
    // leaves the held result untouched. IDLE and DONE share the accept path so
    // a consumed result can be replaced by a new op in the same cycle.
    always_comb begin
        w_state_next  = r_state;
        w_sh_next     = r_sh;
        w_cnt_next    = r_cnt;
        w_kind_next   = r_kind;
        w_result_next = r_result;
        if (flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (w_in_is_shift && (w_in_shamt != 5'd0)) begin
                            w_sh_next    = in_a;
                            w_cnt_next   = w_in_shamt;
                            w_kind_next  = alu_shift_kind(in_ctrl);
                            w_state_next = SHIFT;
                        end else begin
                            w_result_next = w_in_is_shift ? in_a : w_logic_result;
                            w_state_next  = DONE;
                        end
                    end else if ((r_state == DONE) && out_ready) begin
                        w_state_next = IDLE;
                    end
                end
                SHIFT: begin
                    w_sh_next  = w_shifted;
                    w_cnt_next = w_cnt_dec;
                    if (w_cnt_dec == 5'd0) begin
                        w_result_next = w_shifted;
                        w_state_next  = DONE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset clears everything so an op caught
    // mid-shift simply disappears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_kind   <= SH_SLL;
            r_result <= '0;
        end else begin
            r_state  <= w_state_next;
            r_sh     <= w_sh_next;
            r_cnt    <= w_cnt_next;
            r_kind   <= w_kind_next;
            r_result <= w_result_next;
        end
    end

    // Output drive; out_valid is simply "a result is being held".
    always_comb begin
        in_ready   = w_in_ready;
        out_valid  = (r_state == DONE);
        out_result = r_result;
    end

endmodule

// File: tb/tb_alu_iter.sv
// ---------------------------------------------------------------------------
// tb_alu_iter
// Directed-vector bench for alu_iter. Two instances: one with SHIFT_STEP=1
// for the bulk of the vectors and one with SHIFT_STEP=4 for the multi-bit
// shift latency. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_iter;
    import alu_iter_pkg::*;

    logic  clk;
    logic  rst;
    logic  flush;
    logic  inValid;
    logic  inReady;
    word_t inCtrl;
    word_t inA;
    word_t inB;
    logic  outValid;
    logic  outReady;
    word_t outResult;

    logic  flush4;
    logic  inValid4;
    logic  inReady4;
    word_t inCtrl4;
    word_t inA4;
    word_t inB4;
    logic  outValid4;
    logic  outReady4;
    word_t outResult4;

    int total;
    int bad;

    alu_iter #(.SHIFT_STEP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_ctrl    (inCtrl),
        .in_a       (inA),
        .in_b       (inB),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_result (outResult)
    );

    alu_iter #(.SHIFT_STEP(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush4),
        .in_valid   (inValid4),
        .in_ready   (inReady4),
        .in_ctrl    (inCtrl4),
        .in_a       (inA4),
        .in_b       (inB4),
        .out_valid  (outValid4),
        .out_ready  (outReady4),
        .out_result (outResult4)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input word_t got, input word_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one op at a negedge, then counts edges from the accept edge
    // until out_valid is seen (bounded), returning the result and latency.
    task automatic applyStimulus(input bit use4, input word_t ctrl, input word_t a,
                                 input word_t b, output word_t res, output int lat);
        @(negedge clk);
        if (use4) begin
            inCtrl4 = ctrl; inA4 = a; inB4 = b; inValid4 = 1'b1;
        end else begin
            inCtrl = ctrl; inA = a; inB = b; inValid = 1'b1;
        end
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        inValid4 = 1'b0;
        lat = 1;
        while (!(use4 ? outValid4 : outValid) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = use4 ? outResult4 : outResult;
    endtask

    // Directed test sequence.
    initial begin
        word_t res;
        int    lat;
        bit    seen;

        total = 0;
        bad = 0;
        rst = 1'b1;
        flush = 1'b0; inValid = 1'b0; inCtrl = '0; inA = '0; inB = '0; outReady = 1'b1;
        flush4 = 1'b0; inValid4 = 1'b0; inCtrl4 = '0; inA4 = '0; inB4 = '0; outReady4 = 1'b1;

        #12 rst = 1'b0;
        #1;
        checkOutput("rst_out_valid", word_t'(outValid), 32'h0);
        checkOutput("rst_out_result", outResult, 32'h0);
        checkOutput("rst_in_ready", word_t'(inReady), 32'h1);

        applyStimulus(0, ALU_CTRL_ADD, 32'hFFFF_FFFF, 32'h1, res, lat);
        checkOutput("add_wrap", res, 32'h0);
        checkOutput("add_lat", word_t'(lat), 32'd1);
        applyStimulus(0, ALU_CTRL_SUB, 32'h0, 32'h1, res, lat);
        checkOutput("sub_wrap", res, 32'hFFFF_FFFF);
        applyStimulus(0, ALU_CTRL_SLT, 32'h8000_0000, 32'h1, res, lat);
        checkOutput("slt", res, 32'h1);
        applyStimulus(0, ALU_CTRL_SLTU, 32'h8000_0000, 32'h1, res, lat);
        checkOutput("sltu", res, 32'h0);
        applyStimulus(0, ALU_CTRL_SGEU, 32'h8000_0000, 32'h1, res, lat);
        checkOutput("sgeu", res, 32'h1);
        applyStimulus(0, ALU_CTRL_SGE, 32'h8000_0000, 32'h1, res, lat);
        checkOutput("sge", res, 32'h0);
        applyStimulus(0, ALU_CTRL_SEQ, 32'h5, 32'h5, res, lat);
        checkOutput("seq", res, 32'h1);
        applyStimulus(0, ALU_CTRL_SNE, 32'h5, 32'h5, res, lat);
        checkOutput("sne", res, 32'h0);
        applyStimulus(0, ALU_CTRL_OR, 32'h0F00, 32'h00F0, res, lat);
        checkOutput("or", res, 32'h0FF0);

        applyStimulus(0, ALU_CTRL_SRA, 32'h8000_0000, 32'd31, res, lat);
        checkOutput("sra31", res, 32'hFFFF_FFFF);
        checkOutput("sra31_lat", word_t'(lat), 32'd32);
        applyStimulus(0, ALU_CTRL_SLL, 32'h1234_5678, 32'h20, res, lat);
        checkOutput("sll0", res, 32'h1234_5678);
        checkOutput("sll0_lat", word_t'(lat), 32'd1);
        applyStimulus(0, ALU_CTRL_SRL, 32'hF000_0000, 32'hFFFF_FFE4, res, lat);
        checkOutput("srl4", res, 32'h0F00_0000);
        checkOutput("srl4_lat", word_t'(lat), 32'd5);
        applyStimulus(0, ALU_CTRL_SLL, 32'h1, 32'h3, res, lat);
        checkOutput("sll3", res, 32'h8);

        applyStimulus(1, ALU_CTRL_SRA, 32'h8000_0000, 32'd31, res, lat);
        checkOutput("sra31_s4", res, 32'hFFFF_FFFF);
        checkOutput("sra31_s4_lat", word_t'(lat), 32'd9);
        applyStimulus(1, ALU_CTRL_SRL, 32'hFFFF_FFFF, 32'd5, res, lat);
        checkOutput("srl5_s4", res, 32'h07FF_FFFF);
        checkOutput("srl5_s4_lat", word_t'(lat), 32'd3);

        applyStimulus(0, ALU_CTRL_AND, 32'h0000_F0F0, 32'h0000_FF00, res, lat);
        outReady = 1'b0;
        checkOutput("bp_and", res, 32'h0000_F000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", word_t'(outValid), 32'h1);
            checkOutput("bp_result", outResult, 32'h0000_F000);
            checkOutput("bp_in_ready", word_t'(inReady), 32'h0);
        end

        @(negedge clk);
        outReady = 1'b1;
        inValid = 1'b1; inCtrl = ALU_CTRL_XOR; inA = 32'h1; inB = 32'h3;
        @(posedge clk); #1;
        checkOutput("b2b_v1", word_t'(outValid), 32'h1);
        checkOutput("b2b_r1", outResult, 32'h2);
        @(negedge clk);
        inA = 32'hFF; inB = 32'h0F;
        @(posedge clk); #1;
        checkOutput("b2b_v2", word_t'(outValid), 32'h1);
        checkOutput("b2b_r2", outResult, 32'hF0);
        @(negedge clk);
        inA = 32'hAAAA_AAAA; inB = 32'h5555_5555;
        @(posedge clk); #1;
        checkOutput("b2b_v3", word_t'(outValid), 32'h1);
        checkOutput("b2b_r3", outResult, 32'hFFFF_FFFF);
        inValid = 1'b0;

        @(negedge clk);
        inValid = 1'b1; inCtrl = ALU_CTRL_SRL; inA = 32'hFFFF_FFFF; inB = 32'd9;
        @(posedge clk); #1;
        inValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        inValid = 1'b1; inCtrl = ALU_CTRL_ADD; inA = 32'h7; inB = 32'h7;
        @(posedge clk); #1;
        flush = 1'b0;
        inValid = 1'b0;
        checkOutput("flush_in_ready", word_t'(inReady), 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (outValid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("flush_no_valid", word_t'(seen), 32'h0);
        checkOutput("flush_hold_result", outResult, 32'hFFFF_FFFF);
        applyStimulus(0, ALU_CTRL_ADD, 32'd2, 32'd3, res, lat);
        checkOutput("post_flush_add", res, 32'd5);

        @(negedge clk);
        inValid = 1'b1; inCtrl = ALU_CTRL_SLL; inA = 32'h1; inB = 32'd20;
        @(posedge clk); #1;
        inValid = 1'b0;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #3 rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        checkOutput("arst_valid", word_t'(outValid), 32'h0);
        checkOutput("arst_in_ready", word_t'(inReady), 32'h1);
        checkOutput("arst_result", outResult, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (outValid) seen = 1'b1;
        end
        checkOutput("arst_no_valid", word_t'(seen), 32'h0);

        applyStimulus(0, ALU_CTRL_CLR, 32'hFF, 32'h0F, res, lat);
        checkOutput("clr", res, 32'hF0);
        applyStimulus(0, ALU_CTRL_PASS, 32'hDEAD_BEEF, 32'h1234, res, lat);
        checkOutput("pass", res, 32'h1234);
        applyStimulus(0, 32'h0, 32'hDEAD_BEEF, 32'h5678, res, lat);
        checkOutput("ctrl0", res, 32'h5678);
        applyStimulus(0, 32'h0000_FFFF, 32'h1, 32'h9ABC, res, lat);
        checkOutput("ctrl_unknown", res, 32'h9ABC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Execute-stage ALU for the core; consumes the 32-bit alu_ctrl word from the decode stage's ALU control generator, plus two operands from the operand mux.
- Single-cycle for arithmetic, logic and compare ops; shifts run iteratively, SHIFT_STEP bits per cycle, to save area.
- valid/ready handshake on both sides, so writeback/CSR logic can stall it.
- Registered result; one op in flight at a time.

Parameters:
- SHIFT_STEP, 1: bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16, 32.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of the in-flight op and the held result
- in_valid  in  1  operands and ctrl present
- in_ready  out  1  block accepts this cycle
- in_ctrl  in  32  ALU_CTRL_* code (word_t)
- in_a  in  32  operand A (rs1 / CSR old value)
- in_b  in  32  operand B (rs2 / imm / rs1 for CSR)
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_result  out  32  registered result

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, out_result=0, internal shift regs=0. in_ready=1 immediately after reset release.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back ops give 1 result/cycle for non-shift ops.
- States:
  - IDLE: on accept of a non-shift op, or a shift with shamt=0, compute and register the result, then go to DONE. On accept of a shift with shamt!=0, latch a=in_a, cnt=in_b[4:0] and the shift kind, then go to SHIFT.
  - SHIFT: each cycle shifts by min(SHIFT_STEP, cnt) and decrements cnt by the same amount. When cnt reaches 0, register the result and go to DONE.
  - DONE: out_valid=1 and out_result is stable. If out_ready and no new accept, go to IDLE. If out_ready and an accept, process the new op exactly as from IDLE in the same cycle.
- Latency (accept to out_valid):
  - Non-shift ops: 1 cycle.
  - Shifts: 1 + ceil(shamt/SHIFT_STEP) cycles.
  - shamt=31, STEP=1: 32 cycles.
- Op semantics (32-bit, wrap-around arithmetic):
  - ADD: a+b. SUB: a-b.
  - XOR, OR, AND: bitwise. CLR: a & ~b. PASS: b.
  - SLL, SRL: logical shift of a by b[4:0]. SRA: arithmetic shift of a, replicating a[31] each step.
  - SLT, SGE: signed compare. SLTU, SGEU: unsigned compare. SEQ, SNE: equality. All compares return 32'h1 or 32'h0.
  - Any unrecognised ctrl code, including 0: treated as PASS.
- Upper bits in_b[31:5] are ignored for shifts.
- Flush: next edge forces IDLE and out_valid=0; out_result holds its old value. A same-cycle accept is discarded. flush has priority over out_ready and in_valid.
- Backpressure: in DONE with out_ready=0, result and out_valid hold indefinitely and in_ready=0.
- Reset mid-shift: immediate IDLE, no result emitted.

Decomposition:
- Shared types package: ALU_CTRL_* constants (existing) and word_t. Add an alu_is_shift() helper function returning 1 for SLL, SRL, SRA.
- Local enum alu_iter_state_t {IDLE, SHIFT, DONE}, kept local to the module.
- One natural sub-module, alu_logic: combinational, ctrl/a/b to result for all non-shift ops. The FSM, counter and shifter stay in alu_iter.

Test Plan:
- ADD: a=32'hFFFF_FFFF, b=1 -> result 0 one cycle after accept. SUB: a=0, b=1 -> 32'hFFFF_FFFF.
- SLT: a=32'h8000_0000, b=1 -> 1. Same operands with SLTU -> 0. SGEU -> 1. SEQ with a=b=5 -> 1.
- SRA, STEP=1: a=32'h8000_0000, b=31 -> 32'hFFFF_FFFF after 32 cycles. SLL with b=32'h20 (shamt 0) -> a unchanged after 1 cycle. Repeat SRA with STEP=4 -> 9-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> out_result stable, in_ready=0. Then issue back-to-back XOR ops with out_ready=1 -> one result per cycle.
- Flush at cycle 3 of a 10-cycle SRL -> out_valid never rises. The next ADD 2+3 -> 5.
- Async rst pulse mid-SHIFT, between clock edges -> out_valid=0 and in_ready=1 immediately after release. CSR ops: CLR a=32'hFF, b=32'h0F -> 32'hF0. PASS b=32'h1234 -> 32'h1234. ctrl=0 -> b.
